// File: rtl/scroll_renderer_if.sv
// Column-feed, redraw-control and pixel-stream signals of the scroll renderer.
// The master side is the host that feeds columns and reads pixels; the slave
// side is the renderer itself.
interface scroll_renderer_if #(
  parameter int ROWS = 100
);
  logic            col_valid;
  logic [ROWS-1:0] col_data;
  logic            col_ready;
  logic            col_empty;
  logic            clear;
  logic            start;
  logic [7:0]      spr_x;
  logic [6:0]      spr_y;
  logic            busy;
  logic            frame_done;
  logic [7:0]      px_x;
  logic [6:0]      px_y;
  logic [2:0]      px_colour;
  logic            px_plot;

  modport master (
    output col_valid, col_data, clear, start, spr_x, spr_y,
    input  col_ready, col_empty, busy, frame_done,
           px_x, px_y, px_colour, px_plot
  );

  modport slave (
    input  col_valid, col_data, clear, start, spr_x, spr_y,
    output col_ready, col_empty, busy, frame_done,
           px_x, px_y, px_colour, px_plot
  );
endinterface

// File: rtl/scroll_renderer.sv
// Scrolling playfield renderer: holds a COLS x ROWS wall bitmap fed one column
// at a time from the right, and on request redraws the playfield followed by
// a sprite as a one-pixel-per-cycle write stream for a 160x120 VGA adapter.
module scroll_renderer #(
  parameter int         COLS   = 120,
  parameter int         ROWS   = 100,
  parameter int         X_OFF  = 20,
  parameter int         Y_OFF  = 10,
  parameter int         SPR_W  = 4,
  parameter int         SPR_H  = 6,
  parameter logic [2:0] WALL_C = 3'b111,
  parameter logic [2:0] BG_C   = 3'b000,
  parameter logic [2:0] SPR_C  = 3'b100
) (
  input  logic              clk,
  input  logic              reset,
  scroll_renderer_if.slave  bus
);

  localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int IW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int JW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(SPR_W - 1);
  localparam logic [JW-1:0] J_LAST = JW'(SPR_H - 1);

  typedef enum logic [1:0] {IDLE, WALL, SPR, DONE} state_t;

  state_t          state_q, state_d;
  logic [ROWS-1:0] buf_q [COLS];
  logic [ROWS-1:0] buf_d [COLS];
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [7:0]      sx_q, sx_d;
  logic [6:0]      sy_q, sy_d;
  logic            col_empty_q, col_empty_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      px_x_q, px_x_d;
  logic [6:0]      px_y_q, px_y_d;
  logic [2:0]      px_colour_q, px_colour_d;
  logic            px_plot_q, px_plot_d;
  logic [8:0]      sum_x;
  logic [7:0]      sum_y;

  // Next-state, buffer update and scan counters.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    c_d         = c_q;
    r_d         = r_q;
    i_d         = i_q;
    j_d         = j_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    col_empty_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          for (int unsigned c = 0; c < COLS; c++) buf_d[c] = '0;
        end else if (bus.col_valid) begin
          for (int unsigned c = 0; c + 1 < COLS; c++) buf_d[c] = buf_q[c+1];
          buf_d[COLS-1] = bus.col_data;
          col_empty_d   = (bus.col_data == '0);
        end
        if (bus.start) begin
          state_d = WALL;
          c_d     = '0;
          r_d     = '0;
          sx_d    = bus.spr_x;
          sy_d    = bus.spr_y;
        end
      end
      WALL: begin
        if (r_q == R_LAST) begin
          r_d = '0;
          if (c_q == C_LAST) begin
            state_d = SPR;
            i_d     = '0;
            j_d     = '0;
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      SPR: begin
        if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) state_d = DONE;
          else               i_d     = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel for the position the scan is about to occupy. Deriving it from the
  // next-state values (and the post-shift buffer) lets the registered pixel
  // appear the cycle after start, with no pipeline skew between counters and
  // output.
  always_comb begin
    px_x_d       = '0;
    px_y_d       = '0;
    px_colour_d  = '0;
    px_plot_d    = 1'b0;
    sum_x        = {1'b0, sx_d} + 9'(i_d);
    sum_y        = {1'b0, sy_d} + 8'(j_d);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    case (state_d)
      WALL: begin
        px_x_d      = 8'(X_OFF) + 8'(c_d);
        px_y_d      = 7'(Y_OFF) + 7'(r_d);
        px_colour_d = buf_d[c_d][r_d] ? WALL_C : BG_C;
        px_plot_d   = 1'b1;
      end
      SPR: begin
        px_x_d      = sum_x[7:0];
        px_y_d      = sum_y[6:0];
        px_colour_d = SPR_C;
        px_plot_d   = (sum_x < 9'd160) && (sum_y < 8'd120);
      end
      default: ;
    endcase
  end

  // State, buffer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      buf_q        <= '{default: '0};
      c_q          <= '0;
      r_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      col_empty_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      px_x_q       <= '0;
      px_y_q       <= '0;
      px_colour_q  <= '0;
      px_plot_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      c_q          <= c_d;
      r_q          <= r_d;
      i_q          <= i_d;
      j_q          <= j_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      col_empty_q  <= col_empty_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      px_x_q       <= px_x_d;
      px_y_q       <= px_y_d;
      px_colour_q  <= px_colour_d;
      px_plot_q    <= px_plot_d;
    end
  end

  assign bus.col_ready  = (state_q == IDLE);
  assign bus.col_empty  = col_empty_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.px_x       = px_x_q;
  assign bus.px_y       = px_y_q;
  assign bus.px_colour  = px_colour_q;
  assign bus.px_plot    = px_plot_q;

endmodule

// File: tb/tb_scroll_renderer.sv
// Self-checking bench for scroll_renderer with a 4x3 playfield.
module tb_scroll_renderer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int NPIX = COLS * ROWS + 24;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  scroll_renderer_if #(.ROWS(ROWS)) bus ();

  scroll_renderer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       done;
  } pix_t;

  logic [ROWS-1:0] mbuf [COLS];
  pix_t            q [$];
  logic            m_ok = 1'b0;
  logic            e_busy, e_plot, e_fd, e_empty, e_xyc;
  logic [7:0]      e_x;
  logic [6:0]      e_y;
  logic [2:0]      e_c;

  task automatic build_frame(input logic [7:0] sx, input logic [6:0] sy);
    pix_t p;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        p.x = 8'(20 + c); p.y = 7'(10 + r);
        p.c = mbuf[c][r] ? 3'b111 : 3'b000; p.p = 1'b1; p.done = 1'b0;
        q.push_back(p);
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++) begin
        p.x = 8'(int'(sx) + i); p.y = 7'(int'(sy) + j); p.c = 3'b100;
        p.p = ((int'(sx) + i) < 160) && ((int'(sy) + j) < 120); p.done = 1'b0;
        q.push_back(p);
      end
    p = '{x: 8'd0, y: 7'd0, c: 3'd0, p: 1'b0, done: 1'b1};
    q.push_back(p);
  endtask

  always @(posedge clk) begin
    pix_t p;
    if (reset) begin
      for (int c = 0; c < COLS; c++) mbuf[c] = '0;
      q.delete();
      e_busy = 0; e_plot = 0; e_fd = 0; e_empty = 0; e_xyc = 1;
      e_x = '0; e_y = '0; e_c = '0; m_ok = 1'b1;
    end else begin
      e_empty = 0; e_fd = 0;
      if (!e_busy) begin
        if (bus.clear) begin
          for (int c = 0; c < COLS; c++) mbuf[c] = '0;
        end else if (bus.col_valid) begin
          for (int c = 0; c < COLS - 1; c++) mbuf[c] = mbuf[c+1];
          mbuf[COLS-1] = bus.col_data;
          e_empty = (bus.col_data == '0);
        end
        if (bus.start) build_frame(bus.spr_x, bus.spr_y);
      end
      if (q.size() > 0) begin
        p = q.pop_front();
        e_busy = 1; e_plot = p.p; e_fd = p.done; e_xyc = !p.done;
        e_x = p.x; e_y = p.y; e_c = p.c;
      end else begin
        e_busy = 0; e_plot = 0; e_xyc = 0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("col_ready",  32'(bus.col_ready),  32'(!e_busy));
      chk("busy",       32'(bus.busy),       32'(e_busy));
      chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
      chk("col_empty",  32'(bus.col_empty),  32'(e_empty));
      chk("px_plot",    32'(bus.px_plot),    32'(e_plot));
      if (e_xyc) begin
        chk("px_x",      32'(bus.px_x),      32'(e_x));
        chk("px_y",      32'(bus.px_y),      32'(e_y));
        chk("px_colour", 32'(bus.px_colour), 32'(e_c));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [ROWS-1:0] d);
    bus.col_valid = 1'b1; bus.col_data = d;
    step();
    bus.col_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] x, input logic [6:0] y);
    bus.start = 1'b1; bus.spr_x = x; bus.spr_y = y;
    step();
    bus.start = 1'b0;
  endtask

  // Walks one redraw starting on its first pixel; pins one pixel to literal
  // values, measures the frame length and counts visible sprite pixels.
  task automatic run_frame(input bit junk, input int pin_idx, input int pin_x,
                           input int pin_y, input int pin_c, output int spr_plots);
    int fd_at;
    fd_at = -1;
    spr_plots = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == pin_idx) begin
        chk("pin_x",      32'(bus.px_x),      32'(pin_x));
        chk("pin_y",      32'(bus.px_y),      32'(pin_y));
        chk("pin_colour", 32'(bus.px_colour), 32'(pin_c));
      end
      if (k >= COLS * ROWS && k < NPIX && bus.px_plot) spr_plots++;
      if (junk) begin
        bus.col_valid = (k >= 1 && k <= 5);
        bus.clear     = (k >= 1 && k <= 5);
        bus.col_data  = 3'b010;
        if (k >= 1 && k <= 5) chk("ready_while_busy", 32'(bus.col_ready), 32'd0);
      end
      if (bus.frame_done) begin
        fd_at = k;
        break;
      end
      step();
    end
    chk("frame_len", 32'(fd_at), 32'(NPIX));
    step();
    chk("idle_after_frame", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int sp;
    int fd_cnt;
    bus.col_valid = 1'b0; bus.col_data = '0; bus.clear = 1'b0;
    bus.start = 1'b0; bus.spr_x = '0; bus.spr_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_px_x",  32'(bus.px_x), 32'd0);
    chk("reset_plot",  32'(bus.px_plot), 32'd0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", 32'(bus.col_ready), 32'd1);

    // Single column 101, full redraw with sprite at origin.
    push(3'b101);
    do_start(8'd0, 7'd0);
    run_frame(1'b0, 11, 23, 12, 7, sp);
    chk("sprite_plots_full", 32'(sp), 32'd24);

    // Five pushes: buffer becomes 010,011,100,110.
    push(3'b001); push(3'b010); push(3'b011); push(3'b100); push(3'b110);
    do_start(8'd0, 7'd0);
    run_frame(1'b0, 1, 20, 11, 7, sp);

    // Empty column pulses col_empty once, one cycle after acceptance.
    push(3'b000);
    chk("col_empty_pulse", 32'(bus.col_empty), 32'd1);
    step();
    chk("col_empty_gone", 32'(bus.col_empty), 32'd0);

    // Sprite clipped at the bottom-right corner; buffer is 011,100,110,000.
    do_start(8'd158, 7'd117);
    run_frame(1'b0, 0, 20, 10, 7, sp);
    chk("sprite_plots_clip", 32'(sp), 32'd6);

    // Clear wins over a simultaneous column.
    push(3'b111);
    bus.clear = 1'b1; bus.col_valid = 1'b1; bus.col_data = 3'b111;
    step();
    bus.clear = 1'b0; bus.col_valid = 1'b0;
    do_start(8'd0, 7'd0);
    run_frame(1'b0, 9, 23, 10, 0, sp);

    // Column and start together; then column/clear while busy are ignored.
    bus.col_valid = 1'b1; bus.col_data = 3'b111; bus.start = 1'b1;
    step();
    bus.col_valid = 1'b0; bus.start = 1'b0;
    run_frame(1'b1, 9, 23, 10, 7, sp);
    bus.col_valid = 1'b0; bus.clear = 1'b0;
    do_start(8'd0, 7'd0);
    run_frame(1'b0, 9, 23, 10, 7, sp);

    // Reset in mid-redraw aborts it and empties the buffer.
    do_start(8'd0, 7'd0);
    repeat (20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy",  32'(bus.busy),       32'd0);
    chk("abort_plot",  32'(bus.px_plot),    32'd0);
    chk("abort_fd",    32'(bus.frame_done), 32'd0);
    chk("abort_ready", 32'(bus.col_ready),  32'd1);
    fd_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.frame_done) fd_cnt++;
    end
    chk("abort_no_fd", 32'(fd_cnt), 32'd0);
    do_start(8'd0, 7'd0);
    run_frame(1'b0, 9, 23, 10, 0, sp);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
